hdmi_timer_sequencer: RTL and testbench

Sequencer and two-way arbiter that owns the HDMI subsystem interval timer's Avalon-MM slave port. Two requesters (frame pacer, simulation-step engine) share that one timer. The block grants the timer round-robin and programs it with a fixed write sequence. It services the timer interrupt by clearing the status register and steering a one-cycle tick to the current owner. It sits between the requesters and the timer slave, and is the timer's only bus master.

---
 rtl/hdmi_timer_sequencer_if.sv | 25 ++
 rtl/hdmi_timer_sequencer.sv | 145 ++++++++++++++
 tb/tb_hdmi_timer_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_timer_sequencer_if.sv
// Avalon-MM write-only link from the sequencer to the interval timer slave,
// plus the timer's level interrupt back to the sequencer.
interface hdmi_timer_sequencer_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata,
    output tmr_irq
  );
endinterface

// File: rtl/hdmi_timer_sequencer.sv
// Round-robin owner of the HDMI interval timer: programs it with a fixed
// write sequence per grant, acknowledges timeouts and forwards ticks to the owner.
module hdmi_timer_sequencer (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [1:0]                    req,
  input  logic [31:0]                   req_interval0,
  input  logic [31:0]                   req_interval1,
  input  logic                          stop_req,
  output logic [1:0]                    done,
  output logic [1:0]                    tick,
  output logic                          owner,
  output logic                          owner_valid,
  output logic                          busy,
  hdmi_timer_sequencer_if.master        tmr
);

  typedef enum logic [2:0] {
    S_IDLE, S_STOP, S_CLR, S_PER_L, S_PER_H, S_START, S_ACK, S_REL
  } state_t;

  state_t      state, state_nx;
  logic        last_grant;
  logic        stop_pend;
  logic        rel_path;
  logic        winner;
  logic [31:0] load_val;

  logic        stop_now;
  logic        grant_idx;
  logic [31:0] win_interval;
  logic [31:0] load_next;

  assign stop_now = stop_req | stop_pend;

  always_comb begin
    grant_idx = req[0] ? 1'b0 : 1'b1;
    if (&req) grant_idx = ~last_grant;
    win_interval = grant_idx ? req_interval1 : req_interval0;
    // Intervals below 2 clamp to 2 so a timeout can never land on the ACK write.
    load_next = (win_interval < 32'd2) ? 32'd1 : win_interval - 32'd1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (stop_now)                          state_nx = S_REL;
        else if (tmr.tmr_irq && owner_valid)   state_nx = S_ACK;
        else if (|req)                         state_nx = S_STOP;
      end
      S_STOP:  state_nx = S_CLR;
      // CLR is shared by the config and release paths; rel_path picks the exit.
      S_CLR:   state_nx = rel_path ? S_IDLE : S_PER_L;
      S_PER_L: state_nx = S_PER_H;
      S_PER_H: state_nx = S_START;
      S_START: state_nx = S_IDLE;
      S_ACK:   state_nx = S_IDLE;
      S_REL:   state_nx = S_CLR;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tmr.tmr_chipselect = 1'b0;
    tmr.tmr_write_n    = 1'b1;
    tmr.tmr_address    = '0;
    tmr.tmr_writedata  = '0;
    done               = '0;
    tick               = '0;
    case (state)
      S_STOP, S_REL: begin
        tmr.tmr_chipselect = 1'b1;
        tmr.tmr_write_n    = 1'b0;
        tmr.tmr_address    = 3'd1;
        tmr.tmr_writedata  = 16'h0008;
      end
      S_CLR: begin
        tmr.tmr_chipselect = 1'b1;
        tmr.tmr_write_n    = 1'b0;
      end
      S_ACK: begin
        tmr.tmr_chipselect = 1'b1;
        tmr.tmr_write_n    = 1'b0;
        tick               = 2'b01 << owner;
      end
      S_PER_L: begin
        tmr.tmr_chipselect = 1'b1;
        tmr.tmr_write_n    = 1'b0;
        tmr.tmr_address    = 3'd2;
        tmr.tmr_writedata  = load_val[15:0];
      end
      S_PER_H: begin
        tmr.tmr_chipselect = 1'b1;
        tmr.tmr_write_n    = 1'b0;
        tmr.tmr_address    = 3'd3;
        tmr.tmr_writedata  = load_val[31:16];
      end
      S_START: begin
        tmr.tmr_chipselect = 1'b1;
        tmr.tmr_write_n    = 1'b0;
        tmr.tmr_address    = 3'd1;
        tmr.tmr_writedata  = 16'h0007;
        done               = 2'b01 << winner;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      stop_pend   <= 1'b0;
      rel_path    <= 1'b0;
      winner      <= 1'b0;
      load_val    <= '0;
      owner       <= 1'b0;
      owner_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        if (stop_now) begin
          stop_pend   <= 1'b0;
          owner_valid <= 1'b0;
          rel_path    <= 1'b1;
        end else if (!(tmr.tmr_irq && owner_valid) && (|req)) begin
          winner     <= grant_idx;
          last_grant <= grant_idx;
          load_val   <= load_next;
          rel_path   <= 1'b0;
        end
      end else begin
        stop_pend <= stop_pend | stop_req;
      end
      if (state == S_START) begin
        owner       <= winner;
        owner_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_timer_sequencer.sv
// Bench for hdmi_timer_sequencer: expected timer writes are queued as stimulus
// is applied and matched against bus writes observed with a simple timer model.
module tb_hdmi_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [31:0] iv0 = '0;
  logic [31:0] iv1 = '0;
  logic        stop_req = 1'b0;
  logic [1:0]  done, tick;
  logic        owner, owner_valid, busy;
  logic        irq_force = 1'b0;

  hdmi_timer_sequencer_if tif ();

  hdmi_timer_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_interval0 (iv0),
    .req_interval1 (iv1),
    .stop_req      (stop_req),
    .done          (done),
    .tick          (tick),
    .owner         (owner),
    .owner_valid   (owner_valid),
    .busy          (busy),
    .tmr           (tif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer model: status write clears TO (a coinciding timeout is lost),
  // START reloads the counter, counter reloads from the period on every timeout.
  logic [15:0] m_pl, m_ph;
  logic [31:0] m_cnt;
  logic        m_run, m_to, m_ito;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pl <= '0; m_ph <= '0; m_cnt <= '0; m_run <= 1'b0; m_to <= 1'b0; m_ito <= 1'b0;
    end else begin
      if (m_run) begin
        if (m_cnt == 0) begin m_to <= 1'b1; m_cnt <= {m_ph, m_pl}; end
        else m_cnt <= m_cnt - 1;
      end
      if (tif.tmr_chipselect && !tif.tmr_write_n) begin
        case (tif.tmr_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito <= tif.tmr_writedata[0];
            if (tif.tmr_writedata[2]) begin m_run <= 1'b1; m_cnt <= {m_ph, m_pl}; end
            if (tif.tmr_writedata[3]) m_run <= 1'b0;
          end
          3'd2: m_pl <= tif.tmr_writedata;
          3'd3: m_ph <= tif.tmr_writedata;
          default: ;
        endcase
      end
    end
  end
  assign tif.tmr_irq = (m_to & m_ito) | irq_force;

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
    logic [1:0]  dn;
    logic [1:0]  tk;
    logic        ov;
    int          cyc;
  } wr_t;

  wr_t obs[$];
  wr_t exp_q[$];
  int  stray = 0;
  int  checks = 0;
  int  failures = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (tif.tmr_chipselect && !tif.tmr_write_n)
        obs.push_back('{tif.tmr_address, tif.tmr_writedata, done, tick, owner_valid, cyc});
      if (tick != 2'b00 && !(tif.tmr_chipselect && tif.tmr_address == 3'd0)) stray++;
      if (tick != 2'b00 && !owner_valid) stray++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d,
                         input logic [1:0] dn, input logic [1:0] tk);
    exp_q.push_back('{a, d, dn, tk, 1'b0, 0});
  endtask

  task automatic push_cfg(input logic [15:0] lo, input logic [15:0] hi, input logic [1:0] dn);
    push_wr(3'd1, 16'h0008, 2'b00, 2'b00);
    push_wr(3'd0, 16'h0000, 2'b00, 2'b00);
    push_wr(3'd2, lo,       2'b00, 2'b00);
    push_wr(3'd3, hi,       2'b00, 2'b00);
    push_wr(3'd1, 16'h0007, dn,    2'b00);
  endtask

  task automatic wait_obs(input int n, input int budget);
    while (obs.size() < n && budget > 0) begin step(1); budget--; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; stop_req = 1'b0; irq_force = 1'b0; iv0 = '0; iv1 = '0;
    step(2);
    reset_n = 1'b1;
    obs.delete(); exp_q.delete(); stray = 0;
    step(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(2);
    checks++;
    if ({done, tick, owner, owner_valid, busy, tif.tmr_address, tif.tmr_chipselect,
         tif.tmr_write_n, tif.tmr_writedata} !== {2'b00, 2'b00, 3'b000, 3'd0, 1'b0, 1'b1, 16'h0}) begin
      failures++;
      $display("FAIL reset_values got done=%b tick=%b own=%b ov=%b busy=%b a=%0d cs=%b wn=%b d=%h",
               done, tick, owner, owner_valid, busy, tif.tmr_address, tif.tmr_chipselect,
               tif.tmr_write_n, tif.tmr_writedata);
    end
    do_reset();
    step(3);
    checks++;
    if (busy !== 1'b0 || obs.size() != 0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b writes=%0d exp busy=0 writes=0", busy, obs.size());
    end
  endtask

  task automatic test_single();
    wr_t e, o;
    int c0;
    do_reset();
    iv0 = 32'd50000; req = 2'b01; c0 = cyc;
    push_cfg(16'hC34F, 16'h0000, 2'b01);
    wait_obs(5, 20);
    req = 2'b00;
    checks++;
    if (obs.size() < 5 || obs[0].cyc != c0 + 1 || obs[4].cyc != c0 + 5) begin
      failures++;
      $display("FAIL single_latency got n=%0d first=%0d exp first=%0d last=%0d", obs.size(),
               (obs.size() > 0) ? obs[0].cyc : -1, c0 + 1, c0 + 5);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs.size() == 0) begin failures++; $display("FAIL single_write missing exp a=%0d d=%h", e.a, e.d); end
      else begin
        o = obs.pop_front();
        if ({o.a, o.d, o.dn, o.tk} !== {e.a, e.d, e.dn, e.tk}) begin
          failures++;
          $display("FAIL single_write got a=%0d d=%h done=%b tick=%b exp a=%0d d=%h done=%b tick=%b",
                   o.a, o.d, o.dn, o.tk, e.a, e.d, e.dn, e.tk);
        end
      end
    end
    checks++;
    if ({owner, owner_valid, busy} !== 3'b010) begin
      failures++;
      $display("FAIL single_owner got own=%b ov=%b busy=%b exp own=0 ov=1 busy=0", owner, owner_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    wr_t e, o;
    do_reset();
    iv0 = 32'd100; iv1 = 32'h0001_0001; req = 2'b11;
    push_cfg(16'h0063, 16'h0000, 2'b01);
    push_cfg(16'h0000, 16'h0001, 2'b10);
    wait_obs(5, 20);
    req = 2'b10;
    wait_obs(10, 20);
    req = 2'b00;
    checks++;
    if (obs.size() < 10 || obs[5].cyc != obs[4].cyc + 2) begin
      failures++;
      $display("FAIL rr_back_to_back got n=%0d exp n=10 gap=2", obs.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs.size() == 0) begin failures++; $display("FAIL rr_write missing exp a=%0d d=%h", e.a, e.d); end
      else begin
        o = obs.pop_front();
        if ({o.a, o.d, o.dn, o.tk} !== {e.a, e.d, e.dn, e.tk}) begin
          failures++;
          $display("FAIL rr_write got a=%0d d=%h done=%b tick=%b exp a=%0d d=%h done=%b tick=%b",
                   o.a, o.d, o.dn, o.tk, e.a, e.d, e.dn, e.tk);
        end
      end
    end
    checks++;
    if ({owner, owner_valid} !== 2'b11) begin
      failures++;
      $display("FAIL rr_owner got own=%b ov=%b exp own=1 ov=1", owner, owner_valid);
    end
  endtask

  task automatic test_ticks();
    wr_t e, o;
    int s, c0;
    do_reset();
    iv0 = 32'd10; req = 2'b01;
    push_cfg(16'h0009, 16'h0000, 2'b01);
    for (int k = 0; k < 5; k++) push_wr(3'd0, 16'h0000, 2'b00, 2'b01);
    wait_obs(5, 20);
    req = 2'b00;
    s = (obs.size() > 4) ? obs[4].cyc : 0;
    wait_obs(10, 80);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (obs.size() < 5 + k || obs[4 + k].cyc != s + 2 + 10 * k) begin
        failures++;
        $display("FAIL tick_period k=%0d got cyc=%0d exp cyc=%0d", k,
                 (obs.size() >= 5 + k) ? obs[4 + k].cyc : -1, s + 2 + 10 * k);
      end
    end
    stop_req = 1'b1; c0 = cyc;
    step(1);
    stop_req = 1'b0;
    push_wr(3'd1, 16'h0008, 2'b00, 2'b00);
    push_wr(3'd0, 16'h0000, 2'b00, 2'b00);
    step(40);
    checks++;
    if (obs.size() < 11 || obs[10].cyc != c0 + 1 || obs[10].ov !== 1'b0) begin
      failures++;
      $display("FAIL stop_release got n=%0d exp rel_cyc=%0d ov=0", obs.size(), c0 + 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs.size() == 0) begin failures++; $display("FAIL tick_write missing exp a=%0d d=%h", e.a, e.d); end
      else begin
        o = obs.pop_front();
        if ({o.a, o.d, o.dn, o.tk} !== {e.a, e.d, e.dn, e.tk}) begin
          failures++;
          $display("FAIL tick_write got a=%0d d=%h done=%b tick=%b exp a=%0d d=%h done=%b tick=%b",
                   o.a, o.d, o.dn, o.tk, e.a, e.d, e.dn, e.tk);
        end
      end
    end
    checks++;
    if (obs.size() != 0 || stray != 0 || owner_valid !== 1'b0) begin
      failures++;
      $display("FAIL tick_after_stop got extra=%0d stray=%0d ov=%b exp 0 0 0", obs.size(), stray, owner_valid);
    end
  endtask

  task automatic test_clamp();
    wr_t e, o;
    logic [31:0] ivs [4] = '{32'd0, 32'd1, 32'd2, 32'hFFFF_FFFF};
    logic [15:0] los [4] = '{16'h0001, 16'h0001, 16'h0001, 16'hFFFE};
    logic [15:0] his [4] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      iv0 = ivs[i]; req = 2'b01;
      push_cfg(los[i], his[i], 2'b01);
      wait_obs(5, 20);
      req = 2'b00;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (obs.size() == 0) begin failures++; $display("FAIL clamp_write iv=%h missing exp a=%0d d=%h", ivs[i], e.a, e.d); end
        else begin
          o = obs.pop_front();
          if ({o.a, o.d, o.dn, o.tk} !== {e.a, e.d, e.dn, e.tk}) begin
            failures++;
            $display("FAIL clamp_write iv=%h got a=%0d d=%h done=%b exp a=%0d d=%h done=%b",
                     ivs[i], o.a, o.d, o.dn, e.a, e.d, e.dn);
          end
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    wr_t e, o;
    int c0;
    do_reset();
    iv0 = 32'd1000; req = 2'b01;
    push_cfg(16'h03E7, 16'h0000, 2'b01);
    wait_obs(5, 20);
    req = 2'b00;
    step(1);
    stop_req = 1'b1; irq_force = 1'b1; iv1 = 32'd30; req = 2'b10; c0 = cyc;
    step(1);
    stop_req = 1'b0; irq_force = 1'b0;
    push_wr(3'd1, 16'h0008, 2'b00, 2'b00);
    push_wr(3'd0, 16'h0000, 2'b00, 2'b00);
    push_cfg(16'h001D, 16'h0000, 2'b10);
    wait_obs(12, 40);
    req = 2'b00;
    checks++;
    if (obs.size() < 12 || obs[5].cyc != c0 + 1 || obs[5].ov !== 1'b0 || obs[6].ov !== 1'b0
        || obs[7].cyc != c0 + 4) begin
      failures++;
      $display("FAIL simul_order got n=%0d exp rel_cyc=%0d cfg_cyc=%0d ov=0", obs.size(), c0 + 1, c0 + 4);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs.size() == 0) begin failures++; $display("FAIL simul_write missing exp a=%0d d=%h", e.a, e.d); end
      else begin
        o = obs.pop_front();
        if ({o.a, o.d, o.dn, o.tk} !== {e.a, e.d, e.dn, e.tk}) begin
          failures++;
          $display("FAIL simul_write got a=%0d d=%h done=%b tick=%b exp a=%0d d=%h done=%b tick=%b",
                   o.a, o.d, o.dn, o.tk, e.a, e.d, e.dn, e.tk);
        end
      end
    end
    checks++;
    if (stray != 0 || {owner, owner_valid} !== 2'b11) begin
      failures++;
      $display("FAIL simul_final got stray=%0d own=%b ov=%b exp 0 1 1", stray, owner, owner_valid);
    end
  endtask

  task automatic test_reset_mid();
    wr_t e, o;
    int c0;
    do_reset();
    iv0 = 32'd50000; req = 2'b01;
    step(3);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tif.tmr_chipselect, tif.tmr_write_n, busy, owner_valid, done} !== {1'b0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL reset_mid_async got cs=%b wn=%b busy=%b ov=%b done=%b exp cs=0 wn=1 busy=0 ov=0 done=00",
               tif.tmr_chipselect, tif.tmr_write_n, busy, owner_valid, done);
    end
    push_wr(3'd1, 16'h0008, 2'b00, 2'b00);
    push_wr(3'd0, 16'h0000, 2'b00, 2'b00);
    req = 2'b00;
    step(2);
    reset_n = 1'b1;
    step(1);
    req = 2'b01; c0 = cyc;
    push_cfg(16'hC34F, 16'h0000, 2'b01);
    wait_obs(7, 20);
    req = 2'b00;
    checks++;
    if (obs.size() < 7 || obs[2].cyc != c0 + 1 || obs[6].cyc != c0 + 5) begin
      failures++;
      $display("FAIL reset_mid_fresh got n=%0d exp n=7 first=%0d", obs.size(), c0 + 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs.size() == 0) begin failures++; $display("FAIL reset_mid_write missing exp a=%0d d=%h", e.a, e.d); end
      else begin
        o = obs.pop_front();
        if ({o.a, o.d, o.dn, o.tk} !== {e.a, e.d, e.dn, e.tk}) begin
          failures++;
          $display("FAIL reset_mid_write got a=%0d d=%h done=%b exp a=%0d d=%h done=%b",
                   o.a, o.d, o.dn, e.a, e.d, e.dn);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ticks();
    test_clamp();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
